// File: rtl/instr_align.sv
// -----------------------------------------------------------------------------
// instr_align : instruction-align stage between fetch and decode.
//
// Takes one registered, word-aligned fetch word per cycle (two halfwords plus
// PC, valid and exception code) and emits one instruction per cycle to decode.
// 16-bit (RVC) instructions are zero-extended to 32 bits. A 32-bit instruction
// that straddles a word boundary has its low half buffered until the next
// sequential word arrives. When a single word yields two RVC instructions, the
// second is replayed from the buffer while fetch is held via o_stall.
//
// Ports
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_flush                 synchronous pipeline flush (beats i_stall)
//   i_stall                 downstream stall, freezes every register
//   o_stall                 hold request to fetch
//   i_valid, i_pc           fetch word valid and PC (bit 1 = start halfword)
//   i_data0, i_data1        low / high halfword of the fetch word
//   i_except                fetch exception code, 0 = none
//   o_valid, o_pc, o_instr  registered instruction slot to decode
//   o_compressed            slot holds a 16-bit instruction
//   o_except                exception code for the slot
//   i_log_fd                trace descriptor, consumed by simulation-side
//                           tracing only; the datapath ignores it
// -----------------------------------------------------------------------------
module instr_align #(
  parameter int EXCEPT_W = 8
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_flush,
  input  logic                i_stall,
  output logic                o_stall,
  input  logic                i_valid,
  input  logic [31:0]         i_pc,
  input  logic [15:0]         i_data0,
  input  logic [15:0]         i_data1,
  input  logic [EXCEPT_W-1:0] i_except,
  output logic                o_valid,
  output logic [31:0]         o_pc,
  output logic [31:0]         o_instr,
  output logic                o_compressed,
  output logic [EXCEPT_W-1:0] o_except,
  input  logic [31:0]         i_log_fd
);

  localparam logic [1:0] ST_EMPTY  = 2'd0;
  localparam logic [1:0] ST_HALF   = 2'd1;
  localparam logic [1:0] ST_SECOND = 2'd2;

  logic [1:0]          state_q,      state_d;
  logic [15:0]         saved_half_q, saved_half_d;
  logic [31:0]         saved_pc_q,   saved_pc_d;
  logic                valid_q,      valid_d;
  logic [31:0]         pc_q,         pc_d;
  logic [31:0]         instr_q,      instr_d;
  logic                compressed_q, compressed_d;
  logic [EXCEPT_W-1:0] except_q,     except_d;

  // Tracing lives outside the synthesizable core.
  logic unused_log_fd;
  assign unused_log_fd = ^i_log_fd;

  logic        fresh_word;   // process the input word as if from EMPTY
  logic        has_except;
  logic        d0_rvc;
  logic        d1_rvc;
  logic [31:0] seq_pc;

  assign has_except = (i_except != '0);
  assign d0_rvc     = (i_data0[1:0] != 2'b11);
  assign d1_rvc     = (i_data1[1:0] != 2'b11);
  // PC of the word that continues the buffered low half.
  assign seq_pc     = {saved_pc_q[31:2], 2'b00} + 32'd4;

  // SECOND replays a buffered RVC, so fetch must re-present its word.
  assign o_stall = i_stall | (state_q == ST_SECOND);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    saved_half_d = saved_half_q;
    saved_pc_d   = saved_pc_q;
    valid_d      = 1'b0;
    pc_d         = pc_q;
    instr_d      = instr_q;
    compressed_d = compressed_q;
    except_d     = except_q;
    fresh_word   = 1'b0;

    if (i_flush) begin
      instr_d      = '0;
      compressed_d = 1'b0;
      except_d     = '0;
      state_d      = ST_EMPTY;
    end else if (i_stall) begin
      valid_d = valid_q;
    end else begin
      unique case (state_q)
        ST_SECOND: begin
          valid_d      = 1'b1;
          pc_d         = saved_pc_q;
          instr_d      = {16'h0000, saved_half_q};
          compressed_d = 1'b1;
          except_d     = '0;
          state_d      = ST_EMPTY;
        end
        ST_HALF: begin
          if (i_valid) begin
            if (i_pc == seq_pc) begin
              valid_d      = 1'b1;
              pc_d         = saved_pc_q;
              compressed_d = 1'b0;
              if (has_except) begin
                instr_d  = '0;
                except_d = i_except;
                state_d  = ST_EMPTY;
              end else begin
                instr_d      = {i_data0, saved_half_q};
                except_d     = '0;
                saved_half_d = i_data1;
                saved_pc_d   = i_pc + 32'd2;
                state_d      = d1_rvc ? ST_SECOND : ST_HALF;
              end
            end else begin
              // Control flow moved on; the buffered half is stale.
              fresh_word = 1'b1;
            end
          end
        end
        default: fresh_word = i_valid;
      endcase

      if (fresh_word) begin
        state_d = ST_EMPTY;
        if (has_except) begin
          valid_d      = 1'b1;
          pc_d         = i_pc;
          instr_d      = '0;
          compressed_d = 1'b0;
          except_d     = i_except;
        end else if (!i_pc[1]) begin
          valid_d  = 1'b1;
          pc_d     = i_pc;
          except_d = '0;
          if (d0_rvc) begin
            instr_d      = {16'h0000, i_data0};
            compressed_d = 1'b1;
            saved_half_d = i_data1;
            saved_pc_d   = i_pc + 32'd2;
            state_d      = d1_rvc ? ST_SECOND : ST_HALF;
          end else begin
            instr_d      = {i_data1, i_data0};
            compressed_d = 1'b0;
          end
        end else if (d1_rvc) begin
          valid_d      = 1'b1;
          pc_d         = i_pc;
          instr_d      = {16'h0000, i_data1};
          compressed_d = 1'b1;
          except_d     = '0;
        end else begin
          saved_half_d = i_data1;
          saved_pc_d   = i_pc;
          state_d      = ST_HALF;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its inputs, independent of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_EMPTY;
      saved_half_q <= '0;
      saved_pc_q   <= '0;
      valid_q      <= 1'b0;
      pc_q         <= '0;
      instr_q      <= '0;
      compressed_q <= 1'b0;
      except_q     <= '0;
    end else begin
      state_q      <= state_d;
      saved_half_q <= saved_half_d;
      saved_pc_q   <= saved_pc_d;
      valid_q      <= valid_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      compressed_q <= compressed_d;
      except_q     <= except_d;
    end
  end

  assign o_valid      = valid_q;
  assign o_pc         = pc_q;
  assign o_instr      = instr_q;
  assign o_compressed = compressed_q;
  assign o_except     = except_q;

endmodule

// File: doc/instr_align.md
Name: instr_align

Overview:
- Instruction-align (IA) stage. Consumes the registered fetch word from IF: one word-aligned 32-bit word split into two halfwords, plus PC, valid and exception.
- Extracts RVC (16-bit) and 32-bit instructions and emits exactly one instruction per cycle to decode.
- Buffers a dangling halfword when a 32-bit instruction straddles a word boundary.
- Back-pressures IF when one word yields two instructions.

Parameters:
- EXCEPT_W, 8, width of the exception code. 0 means no exception.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_flush  in  1  pipeline flush, synchronous
- i_stall  in  1  downstream stall
- o_stall  out  1  stall to IF. IF holds its output register while this is high.
- i_valid  in  1  fetch word valid
- i_pc  in  32  fetch PC. Bit 1 selects the starting halfword.
- i_data0  in  16  halfword at {i_pc[31:2],2'b00}
- i_data1  in  16  halfword at {i_pc[31:2],2'b10}
- i_except  in  EXCEPT_W  fetch exception code
- o_valid  out  1  instruction valid
- o_pc  out  32  instruction PC
- o_instr  out  32  instruction. RVC is zero-extended to 32 bits.
- o_compressed  out  1  instruction is 16-bit
- o_except  out  EXCEPT_W  exception code for this slot
- i_log_fd  in  32  log file descriptor. 0 disables logging.

Behaviour:
- Classification: a halfword h is RVC iff h[1:0] != 2'b11. Otherwise h is the low half of a 32-bit instruction.
- Outputs are registered; latency from an accepted word to output is 1 cycle.
- Reset: asynchronously drives all outputs to 0 and sets state to EMPTY.
- State registers: state (EMPTY, HALF, SECOND), saved_half[15:0], saved_pc[31:0].
- o_stall = i_stall | (state==SECOND). This is combinational from registered state.
- Priority order: reset, then i_flush, then i_stall, then normal processing.
- Flush: at the clock edge, o_valid, o_instr, o_except and o_compressed go to 0, and state goes to EMPTY. Flush overrides stall.
- i_stall=1: all registers hold.
- EMPTY, i_valid=1, i_except!=0:
  - Emit o_except=i_except, o_pc=i_pc, o_instr=0.
  - Remain in EMPTY.
- EMPTY, i_valid=1, i_pc[1]=0:
  - If data0 is RVC: emit data0 at i_pc.
    - If data1 is RVC, go to SECOND with saved_half=data1 and saved_pc=i_pc+2.
    - Otherwise go to HALF with the same saved values.
  - If data0 is not RVC: emit {data1,data0} at i_pc and remain in EMPTY.
- EMPTY, i_valid=1, i_pc[1]=1: data0 is ignored.
  - If data1 is RVC, emit it at i_pc.
  - Otherwise go to HALF with saved_half=data1 and saved_pc=i_pc. No output this cycle.
- HALF, i_valid=1, i_pc=={saved_pc[31:2],2'b00}+4 (sequential continuation):
  - If i_except!=0: emit the exception at saved_pc with o_instr=0, drop saved_half, go to EMPTY.
  - Otherwise emit {data0,saved_half} at saved_pc. Then treat data1 exactly as in the EMPTY, i_pc[1]=0, data0-RVC branch: go to SECOND or HALF with saved_pc=i_pc+2.
- HALF, i_valid=1, non-sequential PC: discard saved_half and process the word as in EMPTY.
- HALF, i_valid=0: hold state, o_valid=0.
- SECOND: emit saved_half as RVC at saved_pc and go to EMPTY. The input word is ignored because IF is held by o_stall and re-presents it next cycle.
- EMPTY, i_valid=0: o_valid=0.
- o_compressed=1 only for RVC emits. o_except=0 on every non-exception emit.
- Logging: when i_log_fd!=0 and a slot is emitted, log "[IA ] PC @ %h, Instr: %h, C: %d".

Test Plan:
- Reset asserted while in HALF (saved 0x0513) -> outputs immediately 0; after release, word pc=0x3000 data0=0x0093 data1=0x0010 -> o_instr=0x00100093 @0x3000, o_compressed=0.
- Word pc=0x1000 data0=0x4501 data1=0x4585 -> cycle 1: 0x00004501 @0x1000 with compressed=1 and o_stall=1; cycle 2: 0x00004585 @0x1002; word 0x1004 is consumed on cycle 3.
- Word pc=0x2002 data1=0x0513 -> o_valid=0, state HALF. Next word pc=0x2004 data0=0x0000 data1=0x4501 -> 0x00000513 @0x2002 (compressed=0), then 0x4501 @0x2006.
- HALF at 0x2002, next word pc=0x2004 with i_except=0x0C -> o_except=0x0C @0x2002, o_instr=0, state EMPTY.
- HALF at 0x2002, next word pc=0x4000 data0=0x4501 -> saved half dropped, emit 0x4501 @0x4000.
- i_flush during SECOND -> next cycle o_valid=0 and o_stall=0. Separately, i_stall=1 for 3 cycles -> o_* held constant and o_stall=1 throughout.
